// File: rtl/shift_mac_ctrl_pkg.sv
// Shared constants, state type and helpers for the shift-and-add multiply controller.
// Optional feature macro: SHIFT_MAC_SKIP_ZERO_EN (early termination on trailing zero fraction bits).
package shift_mac_ctrl_pkg;

  localparam int W_WIDTH    = 10;
  localparam int FRAC_WIDTH = 8;
  localparam int ACC_WIDTH  = 13;
  localparam int STEPS      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when every fraction bit consumed after step k (frac[6-k:0]) is zero.
  function automatic logic rest_zero(input logic [FRAC_WIDTH-1:0] frac,
                                     input logic [2:0]            k);
    logic [FRAC_WIDTH-1:0] rest;
    rest = frac << ({1'b0, k} + 4'd1);
    return rest == '0;
  endfunction

endpackage

// File: rtl/shift_mac_ctrl.sv
// Sequences a shared external barrel shifter over 8 steps to form w * frac/256 by shift-and-add.
// Optional macro SHIFT_MAC_SKIP_ZERO_EN ends RUN once the remaining fraction bits are all zero.
module shift_mac_ctrl
  import shift_mac_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [W_WIDTH-1:0]   w_in,
  input  logic [FRAC_WIDTH-1:0] frac_in,
  output logic [W_WIDTH-1:0]   bs_w,
  output logic                 bs_s0,
  output logic                 bs_s1,
  output logic                 bs_s2,
  output logic                 bs_x,
  input  logic [W_WIDTH-1:0]   bs_o,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_WIDTH-1:0] prod
);

  // Handshake: start is sampled on a rising edge only while not busy (IDLE or DONE);
  // done is a single-cycle pulse during which prod is valid; prod then holds.

  state_t                 state_q, state_d;
  logic [2:0]             step_q, step_d;
  logic [W_WIDTH-1:0]     w_q, w_d;
  logic [FRAC_WIDTH-1:0]  frac_q, frac_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   prod_q, prod_d;

  logic                   run;
  logic                   last_step;
  logic [ACC_WIDTH-1:0]   term;
  logic [ACC_WIDTH-1:0]   acc_sum;

  assign run  = (state_q == RUN);
  assign term = {{(ACC_WIDTH-W_WIDTH){bs_o[W_WIDTH-1]}}, bs_o};
  assign acc_sum = acc_q + term;

`ifdef SHIFT_MAC_SKIP_ZERO_EN
  assign last_step = (step_q == 3'(STEPS-1)) || rest_zero(frac_q, step_q);
`else
  assign last_step = (step_q == 3'(STEPS-1));
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    w_d     = w_q;
    frac_d  = frac_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          w_d     = w_in;
          frac_d  = frac_in;
          acc_d   = '0;
          step_d  = '0;
          state_d = RUN;
`ifdef SHIFT_MAC_SKIP_ZERO_EN
          if (frac_in == '0) begin
            state_d = DONE;
            prod_d  = '0;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d  = acc_sum;
        step_d = step_q + 3'd1;
        if (last_step) begin
          state_d = DONE;
          step_d  = '0;
          prod_d  = acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      w_q     <= '0;
      frac_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      w_q     <= w_d;
      frac_q  <= frac_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  // Shifter controls are forced to zero whenever no step is in flight.
  assign bs_w  = run ? w_q : '0;
  assign bs_s0 = run & step_q[0];
  assign bs_s1 = run & step_q[1];
  assign bs_s2 = run & step_q[2];
  assign bs_x  = run & frac_q[3'(STEPS-1) - step_q];
  assign busy  = run;
  assign done  = (state_q == DONE);
  assign prod  = prod_q;

endmodule
